// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: BOOT -> FETCH -> EXEC -> [MEM] -> WB, optional HALT.
// Latency: 3 cycles per ALU/branch instruction, 4 for load/store, +1 per memory wait cycle.
// Backpressure: FETCH/MEM hold their requests until ack; halt_req stalls issue at WB.
// Optional retired-instruction counter is built when SEQ_INSTRET_EN is defined.
module core_sequencer #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_load,
    input  logic                 dec_mem,
    input  logic                 dec_mem_read,
    input  logic                 dec_wb,
    input  logic                 dec_branch,
    input  logic                 dec_uncond,
    input  logic                 cmp_true,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 rf_we,
    output logic                 pc_write,
    output logic                 pc_sel,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= FETCH;
                FETCH:   if (imem_ack) state <= EXEC;
                EXEC:    state <= dec_mem ? MEM : WB;
                MEM:     if (dmem_ack) state <= WB;
                WB:      state <= halt_req ? HALT : FETCH;
                HALT:    if (!halt_req) state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end

    // Outputs decode state directly so the async reset clears them immediately.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = !dec_mem_read;
            end
            WB: begin
                rf_we    = dec_wb;
                pc_write = 1'b1;
                pc_sel   = dec_branch & (dec_uncond | cmp_true);
                retire   = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

`ifdef SEQ_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (state == WB) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: boot, ALU, load/store with waits, branches, halt, reset in MEM, counter wrap.
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req, imem_ack, ir_load;
    logic       dec_mem, dec_mem_read, dec_wb, dec_branch, dec_uncond, cmp_true;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       rf_we, pc_write, pc_sel, halt_req, halted, retire;
    logic [3:0] instret;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_instret = '0;

    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_FETCH = 9'b100000000;
    localparam logic [8:0] O_FACK  = 9'b110000000;
    localparam logic [8:0] O_LOAD  = 9'b001000000;
    localparam logic [8:0] O_STORE = 9'b001100000;
    localparam logic [8:0] O_HALT  = 9'b000000001;

    core_sequencer #(.INSTRET_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .dec_mem(dec_mem), .dec_mem_read(dec_mem_read), .dec_wb(dec_wb),
        .dec_branch(dec_branch), .dec_uncond(dec_uncond), .cmp_true(cmp_true),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc_write(pc_write), .pc_sel(pc_sel),
        .halt_req(halt_req), .halted(halted), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, pc_sel, retire, halted}
    task automatic chk_out(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, pc_sel, retire, halted}, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] o_wb(input bit rf, input bit sel);
        return {4'b0000, rf, 1'b1, sel, 1'b1, 1'b0};
    endfunction

    function automatic void bump();
`ifdef SEQ_INSTRET_EN
        exp_instret = exp_instret + 4'd1;
`endif
    endfunction

    // Runs one instruction starting in FETCH; hand-computed pc_sel and cycle count are passed in.
    task automatic run_instr(input string tag, input bit mem, input bit rd, input bit wb,
                             input bit br, input bit unc, input bit cmp,
                             input int iw, input int dw, input bit sel, input int ncyc,
                             input bit halt_in_mem);
        int c = 0;
        dec_mem = mem; dec_mem_read = rd; dec_wb = wb;
        dec_branch = br; dec_uncond = unc; cmp_true = cmp;
        for (int i = 0; i < iw; i++) begin
            chk_out({tag, "_fetch_wait"}, O_FETCH);
            cyc(); c++;
        end
        imem_ack = 1'b1;
        chk_out({tag, "_fetch_ack"}, O_FACK);
        cyc(); c++;
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        chk_out({tag, "_exec"}, O_IDLE);
        cyc(); c++;
        dmem_ack = 1'b0;
        if (mem) begin
            for (int i = 0; i < dw; i++) begin
                chk_out({tag, "_mem_wait"}, rd ? O_LOAD : O_STORE);
                if (halt_in_mem) halt_req = 1'b1;
                cyc(); c++;
            end
            dmem_ack = 1'b1;
            chk_out({tag, "_mem_ack"}, rd ? O_LOAD : O_STORE);
            cyc(); c++;
            dmem_ack = 1'b0;
        end
        chk(tag, instret, exp_instret);
        chk_out({tag, "_wb"}, o_wb(wb, sel));
        cyc(); c++;
        bump();
        chk({tag, "_cycles"}, c, ncyc);
        chk({tag, "_instret"}, instret, exp_instret);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        exp_instret = '0;
        chk_out("rst_outs", O_IDLE);
        chk("rst_instret", instret, 4'd0);
        repeat (n) cyc();
        chk_out("rst_hold", O_IDLE);
        rst_n = 1'b1;
        chk_out("boot", O_IDLE);
        cyc();
        chk_out("boot_fetch", O_FETCH);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 0; dmem_ack = 0; halt_req = 0;
        dec_mem = 0; dec_mem_read = 0; dec_wb = 0; dec_branch = 0; dec_uncond = 0; cmp_true = 0;
        #2;
        do_reset(5);

        run_instr("alu",      0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        run_instr("store_w2", 1, 0, 0, 0, 0, 0, 0, 2, 0, 6, 0);
        run_instr("load_iw1", 1, 1, 1, 0, 0, 0, 1, 0, 0, 5, 0);
        run_instr("br_nt",    0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
        run_instr("br_t",     0, 0, 0, 1, 0, 1, 0, 0, 1, 3, 0);
        run_instr("jal",      0, 0, 1, 1, 1, 0, 0, 0, 1, 3, 0);
        run_instr("nobr_cmp", 0, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0);

        run_instr("halt_ld",  1, 1, 1, 0, 0, 0, 0, 1, 0, 5, 1);
        chk_out("halt_0", O_HALT);
        cyc();
        chk_out("halt_1", O_HALT);
        halt_req = 1'b0;
        chk_out("halt_drop", O_HALT);
        cyc();
        chk_out("halt_resume", O_FETCH);

        // Reset while a store sits in MEM waiting for ack.
        dec_mem = 1; dec_mem_read = 0; dec_wb = 1;
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        cyc();
        chk_out("mid_mem", O_STORE);
        do_reset(2);

        for (int k = 0; k < 16; k++)
            run_instr("wrap", 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("wrap_zero", instret, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
